// File: rtl/baej_pkg.sv
// Shared Baej datapath definitions: word width, return-address stack depth,
// and the sticky error-flag bundle consumed by control/debug.
package baej_pkg;

  localparam int WORD_W    = 16;
  localparam int RAS_DEPTH = 16;

  // Sticky return-address stack error flags.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } ras_flags_t;

endpackage : baej_pkg

// File: rtl/ras_mem.sv
// Return-address storage: DEPTH x WIDTH array, one synchronous write port and
// one asynchronous read port. Contents are never reset.
module ras_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on a write-enabled edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : ras_mem

// File: rtl/ra_stack.sv
// Return-address stack beside the program counting system. Calls push the
// outgoing RA; returns pop the saved RA and pulse restore so the PCS reloads
// it. Overflow/underflow are sticky until reset.
module ra_stack
  import baej_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = RAS_DEPTH,
  localparam int SPW  = $clog2(DEPTH) + 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] ra_in,
  output logic             restore,
  output logic [WIDTH-1:0] ra_restore,
  output logic [SPW-1:0]   depth,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [SPW-1:0] DEPTH_SP = SPW'(DEPTH);
  localparam logic [SPW-1:0] ONE_SP   = SPW'(1);

  logic [SPW-1:0]   sp_q, sp_d;
  logic             restore_q, restore_d;
  logic [WIDTH-1:0] ra_restore_q, ra_restore_d;
  ras_flags_t       flags_q, flags_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] top_data;

  // Top-of-stack address; meaningless (and unused) when the stack is empty.
  assign top_addr = AW'(sp_q - ONE_SP);

  assign empty = (sp_q == '0);
  assign full  = (sp_q == DEPTH_SP);

  ras_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (ra_in),
    .raddr_i (top_addr),
    .rdata_o (top_data)
  );

  // Decide pointer motion, memory write, pop output and flag updates.
  always_comb begin
    sp_d         = sp_q;
    restore_d    = 1'b0;
    ra_restore_d = ra_restore_q;
    flags_d      = flags_q;
    we           = 1'b0;
    waddr        = AW'(sp_q);

    if (push && pop) begin
      if (empty) begin
        // Nothing to return: behave as a plain push and flag the bad pop.
        we                = 1'b1;
        waddr             = AW'(sp_q);
        sp_d              = ONE_SP;
        flags_d.underflow = 1'b1;
      end else begin
        // Replace the top: old top goes out, new RA takes its slot.
        we           = 1'b1;
        waddr        = top_addr;
        ra_restore_d = top_data;
        restore_d    = 1'b1;
      end
    end else if (push) begin
      if (full) begin
        flags_d.overflow = 1'b1;
      end else begin
        we    = 1'b1;
        waddr = AW'(sp_q);
        sp_d  = sp_q + ONE_SP;
      end
    end else if (pop) begin
      if (empty) begin
        flags_d.underflow = 1'b1;
      end else begin
        ra_restore_d = top_data;
        restore_d    = 1'b1;
        sp_d         = sp_q - ONE_SP;
      end
    end
  end

  // Register pointer, pop outputs and sticky flags; reset overrides requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q         <= '0;
      restore_q    <= 1'b0;
      ra_restore_q <= '0;
      flags_q      <= '0;
    end else begin
      sp_q         <= sp_d;
      restore_q    <= restore_d;
      ra_restore_q <= ra_restore_d;
      flags_q      <= flags_d;
    end
  end

  assign depth      = sp_q;
  assign restore    = restore_q;
  assign ra_restore = ra_restore_q;
  assign overflow   = flags_q.overflow;
  assign underflow  = flags_q.underflow;

endmodule : ra_stack

// File: tb/tb_ra_stack.sv
// Directed bench for ra_stack: LIFO order, fill/overflow, underflow,
// simultaneous push+pop (empty and non-empty) and reset priority.
module tb_ra_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int SPW   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset, push, pop;
  logic [WIDTH-1:0] ra_in;
  logic             restore, full, empty, overflow, underflow;
  logic [WIDTH-1:0] ra_restore;
  logic [SPW-1:0]   depth;

  int total = 0;
  int fails = 0;

  ra_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .ra_in      (ra_in),
    .restore    (restore),
    .ra_restore (ra_restore),
    .depth      (depth),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls, then sample 1 time unit after the edge.
  task automatic step(input logic rs, input logic ps, input logic pp, input logic [WIDTH-1:0] d);
    reset = rs;
    push  = ps;
    pop   = pp;
    ra_in = d;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; ra_in = '0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 16'h0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_restore", 32'(restore), 0);
    chk("rst_ra", 32'(ra_restore), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);

    // LIFO order with back-to-back pops
    step(0, 1, 0, 16'h0011);
    step(0, 1, 0, 16'h0022);
    step(0, 1, 0, 16'h0033);
    chk("lifo_depth3", 32'(depth), 3);
    step(0, 0, 1, 16'h0);
    chk("lifo_pop1_ra", 32'(ra_restore), 32'h0033);
    chk("lifo_pop1_rs", 32'(restore), 1);
    step(0, 0, 1, 16'h0);
    chk("lifo_pop2_ra", 32'(ra_restore), 32'h0022);
    chk("lifo_pop2_rs", 32'(restore), 1);
    step(0, 0, 1, 16'h0);
    chk("lifo_pop3_ra", 32'(ra_restore), 32'h0011);
    chk("lifo_pop3_rs", 32'(restore), 1);
    chk("lifo_depth0", 32'(depth), 0);
    chk("lifo_empty", 32'(empty), 1);
    step(0, 0, 0, 16'h0);
    chk("lifo_idle_rs", 32'(restore), 0);
    chk("lifo_hold_ra", 32'(ra_restore), 32'h0011);

    // Fill and overflow
    step(1, 0, 0, 16'h0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 16'h1000 + 16'(i));
    chk("fill_full", 32'(full), 1);
    chk("fill_depth", 32'(depth), 16);
    chk("fill_ovf0", 32'(overflow), 0);
    step(0, 1, 0, 16'hBEEF);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_depth", 32'(depth), 16);
    step(0, 0, 1, 16'h0);
    chk("ovf_pop_ra", 32'(ra_restore), 32'h100F);
    chk("ovf_pop_depth", 32'(depth), 15);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_notfull", 32'(full), 0);

    // Underflow from empty
    step(1, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_restore", 32'(restore), 0);
    chk("unf_ra", 32'(ra_restore), 0);
    chk("unf_depth", 32'(depth), 0);
    step(0, 1, 0, 16'h0042);
    chk("unf_push_depth", 32'(depth), 1);
    step(0, 0, 1, 16'h0);
    chk("unf_pop_ra", 32'(ra_restore), 32'h0042);
    chk("unf_pop_rs", 32'(restore), 1);
    chk("unf_sticky", 32'(underflow), 1);

    // Simultaneous push+pop with depth 2
    step(1, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0100);
    step(0, 1, 0, 16'h0200);
    step(0, 1, 1, 16'h0300);
    chk("pp_ra", 32'(ra_restore), 32'h0200);
    chk("pp_rs", 32'(restore), 1);
    chk("pp_depth", 32'(depth), 2);
    step(0, 0, 1, 16'h0);
    chk("pp_next_ra", 32'(ra_restore), 32'h0300);
    chk("pp_next_depth", 32'(depth), 1);

    // Simultaneous push+pop on empty stack
    step(1, 0, 0, 16'h0);
    step(0, 1, 1, 16'h0055);
    chk("ppe_depth", 32'(depth), 1);
    chk("ppe_unf", 32'(underflow), 1);
    chk("ppe_rs", 32'(restore), 0);
    chk("ppe_ra", 32'(ra_restore), 0);
    step(0, 0, 1, 16'h0);
    chk("ppe_pop_ra", 32'(ra_restore), 32'h0055);
    chk("ppe_pop_rs", 32'(restore), 1);

    // Reset wins over pop at depth 3 (flags set first so clearing is visible)
    step(0, 0, 1, 16'h0);
    step(0, 1, 0, 16'h0A01);
    step(0, 1, 0, 16'h0A02);
    step(0, 1, 0, 16'h0A03);
    chk("rp_depth3", 32'(depth), 3);
    chk("rp_unf_pre", 32'(underflow), 1);
    step(1, 0, 1, 16'h0);
    chk("rp_depth", 32'(depth), 0);
    chk("rp_rs", 32'(restore), 0);
    chk("rp_ra", 32'(ra_restore), 0);
    chk("rp_unf", 32'(underflow), 0);
    chk("rp_ovf", 32'(overflow), 0);
    chk("rp_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule : tb_ra_stack

// File: doc/ra_stack.md
# ra_stack

Return-address stack for the Baej datapath. It sits beside the program counting system.
- On a call it saves the outgoing RA value.
- On a return it pops the saved value and drives the RA-restore path (`restore` / `RArestore`) back into the program counting system.
- This lets nested calls survive the single hardware RA register.

It buffers up to DEPTH return addresses and reports full/empty and sticky error conditions to the control unit.

## Interface
Parameters:
- WIDTH, 16, return-address width; matches PC/RA width.
- DEPTH, 16, number of stack entries; power of two, ≥ 2.

Ports:
- clk  input  1  rising-edge clock, shared with the PC/RA registers.
- reset  input  1  synchronous, active-high reset.
- push  input  1  save `ra_in` on this edge (call).
- pop  input  1  retrieve the top entry (return).
- ra_in  input  WIDTH  current RA register value.
- restore  output  1  one-cycle pulse; wired to the PCS `restore` input and `writeRA` OR-term.
- ra_restore  output  WIDTH  popped address; wired to the PCS `RArestore` input.
- depth  output  $clog2(DEPTH)+1  number of valid entries.
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- overflow  output  1  sticky; a push was attempted while full.
- underflow  output  1  sticky; a pop was attempted while empty.

## Operation
- Storage: DEPTH×WIDTH array plus stack pointer `sp`.
  - `sp` equals `depth`.
  - The top entry is mem[sp-1].
- Push, not full: mem[sp] ← ra_in, sp ← sp+1.
- Push while full:
  - No write; sp unchanged; existing entries are preserved (no wrap, no discard of oldest).
  - overflow ← 1.
- Pop, not empty:
  - ra_restore ← mem[sp-1], sp ← sp-1.
  - restore = 1 in the following cycle.
- Pop while empty:
  - sp unchanged; ra_restore holds its value; restore stays 0.
  - underflow ← 1.
- Push and pop in the same cycle, not empty:
  - ra_restore ← mem[sp-1], and mem[sp-1] ← ra_in in the same edge.
  - sp unchanged; restore pulses next cycle.
  - full stays unchanged, so a full stack does not overflow.
- Push and pop in the same cycle, empty:
  - Performed as a push only (sp ← 1).
  - underflow ← 1; no restore pulse.
- overflow and underflow clear only on reset.
- Reset values:
  - sp = 0, depth = 0, empty = 1, full = 0.
  - restore = 0, ra_restore = 0, overflow = 0, underflow = 0.
  - Array contents are not reset and are don't-care.
- Reset asserted together with push or pop: reset wins; the request is discarded.
- Arithmetic: sp is $clog2(DEPTH)+1 bits; it never exceeds DEPTH and never goes below 0 (guarded, not wrapped).

## Timing
- All state updates on the rising edge of clk.
- depth, full and empty are combinational from sp and are valid the cycle after the request edge.
- Pop latency:
  - Pop is sampled at edge N.
  - restore and ra_restore are valid during cycle N+1.
  - The PCS latches RA at edge N+1.
  - restore deasserts in cycle N+2 unless a new pop was accepted at edge N+1.
- Back-to-back pops in consecutive cycles:
  - restore stays high.
  - ra_restore updates every cycle with successive entries.
- ra_restore holds its last popped value until the next successful pop.
- No combinational path from push/pop/ra_in to restore or ra_restore.

## Structure
- Shared package `baej_pkg`:
  - WORD_W = 16.
  - RAS_DEPTH = 16.
  - A `ras_flags_t` bundle for overflow/underflow, consumed by control/debug.
- One sub-module `ras_mem`:
  - DEPTH×WIDTH array with one synchronous write port and one asynchronous read port (addr = sp-1).
  - No reset.
- The pointer, flag and output-register logic lives in `ra_stack`.

## Test plan
- Reset, then push 0x0011, 0x0022, 0x0033 on consecutive cycles, then pop three times:
  - ra_restore sequence 0x0033, 0x0022, 0x0011.
  - restore high for three consecutive cycles.
  - depth ends at 0; empty = 1.
- Fill with 16 pushes (0x1000 + i), then push 0xBEEF:
  - full = 1, overflow = 1, depth = 16.
  - The subsequent pop returns 0x100F, not 0xBEEF.
- Pop from empty after reset:
  - underflow = 1, restore stays 0, ra_restore = 0x0000.
  - A later push/pop of 0x0042 works normally.
- With depth 2 (top 0x0200), assert push 0x0300 and pop together:
  - ra_restore = 0x0200, depth stays 2.
  - The next pop returns 0x0300.
- Assert push + pop together on an empty stack with ra_in = 0x0055:
  - depth = 1, underflow = 1, no restore pulse.
  - The next pop returns 0x0055.
- Assert reset in the same cycle as a pop with depth 3:
  - Next cycle depth = 0, restore = 0, ra_restore = 0, flags cleared.
